// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences single load/store accesses to a word-wide data RAM. Byte and
//   halfword stores are done as read-modify-write. Loads return the raw RAM
//   word on rd_RAM with the low address bits on lowerAddr, so a later stage
//   can do the lane select and sign extension.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Defined:   misaligned requests complete at once with misalign=1 and do
//              not touch the RAM.
//   Undefined: the misalign port is absent and misaligned requests are
//              force-aligned.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_we                  1 = store, 0 = load
//   TYPE_B / TYPE_H         byte / halfword access (byte wins); neither = word
//   addr, wdata             byte address, right-aligned store data
//   ram_addr, ram_we        RAM word address and write strobe
//   ram_wdata, ram_rdata    RAM write word / read word (one-cycle read latency)
//   rd_RAM, lowerAddr       captured load word and latched addr[1:0]
//   done                    one-cycle completion pulse
//   misalign                misaligned-request flag (MISALIGN_TRAP_EN only)
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        TYPE_B,
    input  logic        TYPE_H,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [29:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [31:0] rd_RAM,
    output logic [1:0]  lowerAddr,
    output logic        done
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q, byte_q, half_q;
    logic [31:0] wdata_q;
    logic [1:0]  lower_addr_q;
    logic [29:0] ram_addr_q;
    logic [31:0] rd_ram_q;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic        done_q, ram_we_q;
    logic        accept;
    logic        req_misaligned;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q;
`endif

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        req_misaligned = !TYPE_B &&
                         ((TYPE_H && addr[0]) || (!TYPE_H && (addr[1:0] != 2'b00)));
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_misaligned)
                        state_d = DONE;
                    else if (!req_we || TYPE_B || TYPE_H)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD:      state_d = WAIT;
            WAIT:    state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane merge for sub-word stores; halfword lane uses addr[1] only, which
    // also force-aligns an odd halfword address.
    always_comb begin
        merged = ram_rdata;
        if (byte_q) begin
            case (lower_addr_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged     = ram_rdata;
            endcase
        end else if (lower_addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0]  = wdata_q[15:0];
        end
    end

    // ram_we_q is registered from state_d, so it is high exactly while in WR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            half_q       <= 1'b0;
            wdata_q      <= '0;
            lower_addr_q <= '0;
            ram_addr_q   <= '0;
            rd_ram_q     <= '0;
            merge_q      <= '0;
            done_q       <= 1'b0;
            ram_we_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= (state_d == DONE);
            ram_we_q <= (state_d == WR);
`ifdef MISALIGN_TRAP_EN
            misalign_q <= accept && req_misaligned;
`endif
            if (accept) begin
                we_q         <= req_we;
                byte_q       <= TYPE_B;
                half_q       <= TYPE_H;
                wdata_q      <= wdata;
                lower_addr_q <= addr[1:0];
                ram_addr_q   <= addr[31:2];
            end
            if (state_q == WAIT) begin
                if (we_q)
                    merge_q  <= merged;
                else
                    rd_ram_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        ram_wdata = '0;
        if (state_q == WR)
            ram_wdata = (byte_q || half_q) ? merge_q : wdata_q;
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign rd_RAM    = rd_ram_q;
    assign lowerAddr = lower_addr_q;
    assign done      = done_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, TYPE_B, TYPE_H;
    logic [31:0] addr, wdata;
    logic [29:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata, rd_RAM;
    logic [1:0]  lowerAddr;
    logic        done;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .TYPE_B    (TYPE_B),
        .TYPE_H    (TYPE_H),
        .addr      (addr),
        .wdata     (wdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rd_RAM    (rd_RAM),
        .lowerAddr (lowerAddr),
        .done      (done)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    // Environment RAM: 16 words, registered read, backdoor preload port.
    logic [31:0] env_mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        ram_rdata <= env_mem[ram_addr[3:0]];
        if (pre_en)
            env_mem[pre_idx] <= pre_val;
        else if (ram_we)
            env_mem[ram_addr[3:0]] <= ram_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd;
    logic [31:0] last_wdata;
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx[3:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] wd,
                                              input logic b, input logic [1:0] lo);
        int unsigned sh;
        logic [31:0] mask;
        if (b) begin
            sh   = 8 * lo;
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = lo[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Issues one request starting at a negedge and follows it to done.
    task automatic do_req(input logic we, input logic b, input logic h,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit b2b, input bit abort_in_wr);
        int waits = 0;
        bit accepted = 0;
        int idx, exp_done, exp_we_at, done_at, we_cnt, we_at, zero_bad;
        logic mis, trap_case, mis_seen;
        logic [31:0] exp_word, we_data;
        req_valid = 1'b1; req_we = we; TYPE_B = b; TYPE_H = h; addr = a; wdata = wd;
        while (!accepted && waits < 10) begin
            if (req_ready) begin
                @(posedge clk);
                accepted = 1;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        check("accept", 32'(accepted), 32'd1);
        if (b2b) check("b2b_gap", waits, 1);
        if (!accepted) begin
            req_valid = 1'b0;
            return;
        end
        #1;
        // Busy-time noise on the request inputs must be ignored.
        req_valid = 1'($urandom % 2); req_we = 1'($urandom % 2);
        TYPE_B = 1'($urandom % 2); TYPE_H = 1'($urandom % 2);
        addr = $urandom; wdata = $urandom;

        idx       = int'(a[5:2]);
        mis       = !b && ((h && a[0]) || (!h && a[1:0] != 2'b00));
        trap_case = TRAP && mis;
        exp_done  = trap_case ? 1 : (!we ? 3 : ((b || h) ? 4 : 2));
        exp_we_at = (trap_case || !we) ? 0 : ((b || h) ? 3 : 1);
        exp_word  = (b || h) ? merge_ref(ref_mem[idx], wd, b, a[1:0]) : wd;

        done_at = 0; we_cnt = 0; we_at = 0; zero_bad = 0; we_data = '0; mis_seen = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                we_at   = n;
                we_data = ram_wdata;
                if (abort_in_wr) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("abort_ram_we", 32'(ram_we), 32'd0);
                    check("abort_done", 32'(done), 32'd0);
                    check("abort_ready", 32'(req_ready), 32'd1);
                    check("abort_rd_RAM", rd_RAM, 32'd0);
                    check("abort_ram_addr", 32'(ram_addr), 32'd0);
                    rst_n = 1'b1;
                    req_valid = 1'b0;
                    exp_rd = '0;
                    return;
                end
            end else if (ram_wdata !== 32'd0) begin
                zero_bad++;
            end
            if (done) begin
                done_at = n;
`ifdef MISALIGN_TRAP_EN
                mis_seen = misalign;
`endif
                break;
            end
        end
        req_valid = 1'b0;

        check("done_cycle", done_at, exp_done);
        check("we_pulses", we_cnt, (exp_we_at != 0) ? 1 : 0);
        check("wdata_zero_outside_wr", zero_bad, 0);
        if (exp_we_at != 0) begin
            check("we_cycle", we_at, exp_we_at);
            check("ram_wdata", we_data, exp_word);
            ref_mem[idx] = exp_word;
        end
        last_wdata = we_data;
        if (!we && !trap_case) exp_rd = ref_mem[idx];
        check("rd_RAM", rd_RAM, exp_rd);
        check("lowerAddr", 32'(lowerAddr), 32'(a[1:0]));
        check("ram_addr", 32'(ram_addr), 32'(a[31:2]));
        check("misalign", 32'(mis_seen), 32'(trap_case));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; TYPE_B = 1'b0; TYPE_H = 1'b0;
        addr = '0; wdata = '0; exp_rd = '0; last_wdata = '0;
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_rd_RAM", rd_RAM, 32'd0);
        check("rst_lowerAddr", 32'(lowerAddr), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        poke(4, 32'hA1B2C3D4);
        do_req(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, 0);
        check("load_word_rd", rd_RAM, 32'hA1B2C3D4);

        poke(4, 32'h11223344);
        do_req(1'b1, 1'b1, 1'b0, 32'h13, 32'h0000_00EE, 0, 0);
        check("byte_store_word", last_wdata, 32'hEE223344);

        poke(4, 32'h11223344);
        do_req(1'b1, 1'b0, 1'b1, 32'h12, 32'h0000_BEEF, 0, 0);
        check("half_store_word", last_wdata, 32'hBEEF3344);

        do_req(1'b1, 1'b0, 1'b0, 32'h20, 32'hCAFEF00D, 1, 0);
        check("word_store_word", last_wdata, 32'hCAFEF00D);

        poke(4, 32'h55667788);
        do_req(1'b0, 1'b0, 1'b1, 32'h11, 32'h0, 0, 0);

        poke(4, 32'h11223344);
        do_req(1'b1, 1'b1, 1'b0, 32'h13, 32'h0000_00EE, 0, 1);
        poke(4, 32'h11223344);

        for (int t = 0; t < 300; t++) begin
            int gap;
            gap = (t == 0) ? 1 : int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            do_req(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 2),
                   {$urandom_range(0, 32'h03FF_FFFF) << 6} | 32'($urandom_range(0, 63)),
                   $urandom, (gap == 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
